// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide core.
// State encoding, fixed latencies and the radix-4 Booth select encoding.
package multdiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        B_ZERO = 3'd0,
        B_PA   = 3'd1,
        B_P2A  = 3'd2,
        B_NA   = 3'd3,
        B_N2A  = 3'd4
    } booth_sel_e;

    localparam int MUL_LAT = 17;
    localparam int DIV_LAT = 33;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_iter_core_if.sv
// Operand/control/result bundle between the pipeline and the multiply/divide core.
// The pipeline side is the master; the core is the slave.
interface multdiv_iter_core_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_iter_core_booth.sv
// Radix-4 Booth recoder: maps the 3-bit multiplier window {b[i+1], b[i], b[i-1]}
// to a partial-product select in {0, +A, +2A, -A, -2A}.
module booth_recode_r4
    import multdiv_pkg::*;
(
    input  logic [2:0] win,
    output booth_sel_e sel
);

    always_comb begin
        sel = B_ZERO;
        unique case (win)
            3'b000, 3'b111: sel = B_ZERO;
            3'b001, 3'b010: sel = B_PA;
            3'b011:         sel = B_P2A;
            3'b100:         sel = B_N2A;
            3'b101, 3'b110: sel = B_NA;
            default:        sel = B_ZERO;
        endcase
    end

endmodule

// File: rtl/multdiv_iter_core.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (radix-2 non-restoring).
// Optional MULTDIV_EARLY_DIV0_EN: a divide by zero completes one cycle after its start.
module multdiv_iter_core
    import multdiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = MUL_LAT - 1,
    parameter int DIV_ITERS = DIV_LAT - 1
) (
    input  logic                clk,
    input  logic                reset,
    multdiv_iter_core_if.slave  bus
);

    state_e                  state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [2*WIDTH:0]        prod_q, prod_d;
    logic signed [WIDTH-1:0] mcand_q, mcand_d;
    logic signed [WIDTH+1:0] rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [WIDTH-1:0]        dvsr_q, dvsr_d;
    logic                    neg_q, neg_d;
    logic                    div0_q, div0_d;
    logic                    dovf_q, dovf_d;
    logic [WIDTH-1:0]        res_q, res_d;
    logic                    exc_q, exc_d;
    logic                    rdy_q, rdy_d;

    booth_sel_e              sel;
    logic signed [WIDTH+1:0] mcand_ext, pp, sum;
    logic signed [WIDTH+1:0] dvsr_ext, rem_sh, rem_step, rem_fix;
    logic [WIDTH:0]          prod_hi;
    logic                    start;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    booth_recode_r4 u_booth (
        .win (prod_q[2:0]),
        .sel (sel)
    );

    assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
    assign mcand_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    assign dvsr_ext = {2'b00, dvsr_q};
    assign prod_hi  = prod_q[2*WIDTH:WIDTH];

    // Booth partial product and 34-bit accumulate on the sign-extended high half.
    always_comb begin
        pp = '0;
        unique case (sel)
            B_PA:    pp = mcand_ext;
            B_P2A:   pp = mcand_ext <<< 1;
            B_NA:    pp = -mcand_ext;
            B_N2A:   pp = -(mcand_ext <<< 1);
            default: pp = '0;
        endcase
        sum = $signed({{2{prod_q[2*WIDTH]}}, prod_q[2*WIDTH:WIDTH+1]}) + pp;
    end

    // Non-restoring step: add or subtract the divisor depending on the remainder sign.
    always_comb begin
        rem_sh   = $signed({rem_q[WIDTH:0], quo_q[WIDTH-1]});
        rem_step = rem_q[WIDTH+1] ? rem_sh + dvsr_ext : rem_sh - dvsr_ext;
        rem_fix  = rem_q[WIDTH+1] ? rem_q + dvsr_ext : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        div0_d  = div0_q;
        dovf_d  = dovf_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;

        if (start) begin
            cnt_d = '0;
            if (bus.ctrl_MULT) begin
                state_d = S_MUL;
                mcand_d = $signed(bus.data_operandA);
                prod_d  = {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            end else begin
                state_d = S_DIV;
                rem_d   = '0;
                quo_d   = mag($signed(bus.data_operandA));
                dvsr_d  = mag($signed(bus.data_operandB));
                neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                div0_d  = (bus.data_operandB == '0);
                dovf_d  = (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
`ifdef MULTDIV_EARLY_DIV0_EN
                // Skip straight to the finishing step; the div0 flag forces the result.
                if (bus.data_operandB == '0) cnt_d = 6'(DIV_ITERS);
`else
`endif
            end
        end else begin
            unique case (state_q)
                S_MUL: begin
                    if (cnt_q < 6'(MUL_ITERS)) begin
                        prod_d = {sum, prod_q[WIDTH:2]};
                        cnt_d  = cnt_q + 6'd1;
                    end else begin
                        state_d = S_DONE;
                        res_d   = prod_q[WIDTH:1];
                        exc_d   = !((prod_hi == '0) || (prod_hi == '1));
                        rdy_d   = 1'b1;
                    end
                end
                S_DIV: begin
                    if (cnt_q < 6'(DIV_ITERS)) begin
                        rem_d = rem_step;
                        quo_d = {quo_q[WIDTH-2:0], ~rem_step[WIDTH+1]};
                        cnt_d = cnt_q + 6'd1;
                    end else begin
                        state_d = S_DONE;
                        rem_d   = rem_fix;
                        rdy_d   = 1'b1;
                        if (div0_q) begin
                            res_d = '0;
                            exc_d = 1'b1;
                        end else if (dovf_q) begin
                            res_d = INT_MIN;
                            exc_d = 1'b1;
                        end else begin
                            res_d = neg_q ? -quo_q : quo_q;
                            exc_d = 1'b0;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            dovf_q  <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
            div0_q  <= div0_d;
            dovf_q  <= dovf_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;

endmodule
